// File: rtl/cache_pkg.sv
// Shared cache-memory constants and types: SRAM geometry/timing, cell FSM states and request capture.
package cache_pkg;

  localparam int SRAM_ADDR_WIDTH = 16;
  localparam int SRAM_LATENCY    = 7;
  localparam int CELL_DATA_WIDTH = 8;
  localparam int NUM_BYTE_LANES  = 4;
  localparam int DROP_CNT_WIDTH  = 8;

  typedef enum logic {CELL_IDLE, CELL_BUSY} sram_cell_state_t;

  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [CELL_DATA_WIDTH-1:0] data;
    logic                       is_write;
    logic                       is_read;
  } sram_req_t;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_latency_timer.sv
// Latency timer: load starts the count at 1, done is high while the count equals LATENCY.
// The count self-clears after done; reusable by the cache controller for its issue wait.
module sram_latency_timer #(
  parameter int LATENCY = 7,
  parameter int CW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign done = (cnt_q == CW'(LATENCY));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(1);
    end else if (done) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_cell.sv
// One byte-lane SRAM cell: a strobe accepted at edge T completes at edge T+SRAM_LATENCY.
// No backpressure: strobes seen while busy are dropped and counted in drop_cnt (saturating).
module sram_cell #(
  parameter int DATA_WIDTH      = cache_pkg::CELL_DATA_WIDTH,
  parameter int SRAM_ADDR_WIDTH = cache_pkg::SRAM_ADDR_WIDTH,
  parameter int DEPTH           = 65536,
  parameter int SRAM_LATENCY    = cache_pkg::SRAM_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SRAM_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       sense_en,
  input  logic                       wen,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);
  import cache_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  sram_cell_state_t      state_q, state_d;
  sram_req_t             req_q, req_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  timer_load;
  logic                  timer_done;
  logic                  mem_we;
  logic                  strobe;
  logic [IDX_W-1:0]      mem_idx;

  assign strobe  = sense_en | wen;
  assign mem_idx = req_q.addr[IDX_W-1:0];

  sram_latency_timer #(
    .LATENCY (SRAM_LATENCY),
    .CW      (8)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    timer_load   = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      CELL_IDLE: begin
        if (strobe) begin
          // Upper address bits are dropped here so addresses wrap modulo DEPTH.
          req_d.addr             = '0;
          req_d.addr[IDX_W-1:0]  = addr[IDX_W-1:0];
          req_d.data             = din;
          req_d.is_write         = wen;
          req_d.is_read          = sense_en;
          timer_load             = 1'b1;
          state_d                = CELL_BUSY;
        end
      end
      CELL_BUSY: begin
        if (strobe) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
        if (timer_done) begin
          state_d = CELL_IDLE;
          mem_we  = req_q.is_write;
          if (req_q.is_read) begin
            // Write wins on a combined strobe; the written byte is echoed on dout.
            dout_d       = req_q.is_write ? req_q.data : mem[mem_idx];
            dout_valid_d = 1'b1;
          end
        end
      end
      default: state_d = CELL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CELL_IDLE;
      req_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= req_q.data;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == CELL_BUSY);
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sram_cell.sv
// Scoreboard bench for sram_cell with DEPTH=256 and SRAM_LATENCY=7.
module tb_sram_cell;

  localparam int L       = 7;
  localparam int DEPTH_T = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        sense_en;
  logic        wen;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        busy;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] mdl [DEPTH_T];
  int         exp_drop = 0;
  logic [7:0] exp_dout = 8'h00;

  sram_cell #(
    .DATA_WIDTH      (8),
    .SRAM_ADDR_WIDTH (16),
    .DEPTH           (DEPTH_T),
    .SRAM_LATENCY    (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .din        (din),
    .sense_en   (sense_en),
    .wen        (wen),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", {31'd0, dout_valid}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_data", {24'd0, dout}, {24'd0, mon_e.data});
        chk("rd_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the sampling edge.
  task automatic issue(input logic r, input logic w, input logic [15:0] a,
                       input logic [7:0] d, output int t0);
    exp_t e;
    sense_en = r;
    wen      = w;
    addr     = a;
    din      = d;
    @(negedge clk);
    t0       = cyc;
    sense_en = 1'b0;
    wen      = 1'b0;
    if (r) begin
      e.data   = w ? d : mdl[a[7:0]];
      e.cyc    = t0 + L;
      exp_dout = e.data;
      sbq.push_back(e);
    end
    if (w) mdl[a[7:0]] = d;
    chk("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input int t0, input string tag);
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk({tag, "_done_cyc"}, cyc, t0 + L);
  endtask

  int         t;
  logic [7:0] prev;
  logic       m_busy;
  int         m_cnt;
  exp_t       se;

  initial begin
    rst = 1'b1; sense_en = 1'b0; wen = 1'b0; addr = '0; din = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read with a cycle-by-cycle busy profile
    issue(1'b0, 1'b1, 16'h0010, 8'hA5, t);
    for (int k = 1; k < L; k++) begin
      @(negedge clk);
      chk("busy_hold", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("wr_done_cyc", cyc, t + L);
    chk("dout_hold", {24'd0, dout}, {24'd0, exp_dout});
    issue(1'b1, 1'b0, 16'h0010, 8'h00, t);
    wait_idle(t, "rd1");

    // Writes at T3/T4 of a read are dropped and not performed
    issue(1'b1, 1'b0, 16'h0010, 8'h00, t);
    repeat (2) @(negedge clk);
    wen = 1'b1; addr = 16'h0010; din = 8'h5A;
    repeat (2) @(negedge clk);
    wen = 1'b0;
    exp_drop += 2;
    wait_idle(t, "drop_rd");
    chk("drop_two", {24'd0, drop_cnt}, exp_drop);
    issue(1'b1, 1'b0, 16'h0010, 8'h00, t);
    wait_idle(t, "drop_verify");

    // Strobe in the completion cycle is dropped; the next cycle is accepted
    issue(1'b1, 1'b0, 16'h0010, 8'h00, t);
    repeat (L - 1) @(negedge clk);
    sense_en = 1'b1; addr = 16'h0010;
    @(negedge clk);
    sense_en = 1'b0;
    exp_drop += 1;
    chk("done_edge_busy", {31'd0, busy}, 32'd0);
    chk("done_edge_drop", {24'd0, drop_cnt}, exp_drop);
    issue(1'b0, 1'b1, 16'h0030, 8'h66, t);
    wait_idle(t, "b2b_wr");
    chk("wr_no_dout_change", {24'd0, dout}, {24'd0, exp_dout});

    // Simultaneous strobes: write-through read
    issue(1'b1, 1'b1, 16'h0002, 8'h3C, t);
    wait_idle(t, "simul");
    issue(1'b1, 1'b0, 16'h0002, 8'h00, t);
    wait_idle(t, "simul_rd");

    // Address wrap modulo DEPTH
    issue(1'b0, 1'b1, 16'h0105, 8'h77, t);
    wait_idle(t, "wrap_wr");
    issue(1'b1, 1'b0, 16'h0005, 8'h00, t);
    wait_idle(t, "wrap_rd");
    issue(1'b0, 1'b1, 16'h00FF, 8'hC3, t);
    wait_idle(t, "top_wr");
    issue(1'b1, 1'b0, 16'hFFFF, 8'h00, t);
    wait_idle(t, "top_rd");

    // Reset mid-write discards the write
    issue(1'b0, 1'b1, 16'h0020, 8'h11, t);
    wait_idle(t, "pre_wr");
    prev = mdl[8'h20];
    issue(1'b0, 1'b1, 16'h0020, 8'hFF, t);
    mdl[8'h20] = prev;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, dout_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_drop = 0;
    exp_dout = 8'h00;
    chk("abort_dout", {24'd0, dout}, 32'd0);
    chk("abort_drop", {24'd0, drop_cnt}, 32'd0);
    repeat (L + 2) @(negedge clk);
    chk("abort_no_valid_q", sbq.size(), 0);
    issue(1'b1, 1'b0, 16'h0020, 8'h00, t);
    wait_idle(t, "abort_rd");

    // Held read strobe: one read per L+1 cycles, drops saturate at 255
    m_busy = 1'b0;
    m_cnt  = 0;
    sense_en = 1'b1; addr = 16'h0010;
    for (int i = 0; i < 300; i++) begin
      if (i == 100) chk("sat_mid_drop", {24'd0, drop_cnt}, exp_drop);
      if (!m_busy) begin
        m_busy  = 1'b1;
        m_cnt   = 1;
        se.data = mdl[8'h10];
        se.cyc  = cyc + 1 + L;
        sbq.push_back(se);
      end else begin
        if (exp_drop < 255) exp_drop++;
        if (m_cnt == L) m_busy = 1'b0;
        else m_cnt++;
      end
      @(negedge clk);
    end
    sense_en = 1'b0;
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("sat_drop", {24'd0, drop_cnt}, exp_drop);
    chk("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
